gigerx_rx_wr_ctrl: RTL and testbench

Write-side controller for the gigabit receive byte FIFO (256 x 8, single clock). It takes the raw GMII-style byte stream from the receive PHY interface, strips preamble/SFD, decides per frame whether the FIFO has room to admit it, and drives the FIFO write port. For every frame it reports a completion event with length and status to the downstream frame/descriptor logic.

---
 rtl/gigerx_rx_wr_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_gigerx_rx_wr_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gigerx_rx_wr_ctrl.sv
// Gigabit RX write-side controller: preamble/SFD strip, admission, FIFO write.
// Optional GIGERX_RX_CRC_STRIP_EN holds back the trailing 4 FCS bytes.
module gigerx_rx_wr_ctrl #(
  parameter int DEPTH      = 256,
  parameter int ADMIT_FREE = 64,
  parameter int MAX_LEN    = 1522
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_en,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  input  logic [8:0]  fifo_usedw,
  input  logic        fifo_full,
  output logic        fifo_wrreq,
  output logic [7:0]  fifo_data,
  output logic        frm_done,
  output logic [13:0] frm_len,
  output logic [1:0]  frm_status,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    RECV,
    DISCARD
  } state_t;

  localparam logic [1:0]  ST_GOOD  = 2'b00;
  localparam logic [1:0]  ST_ERR   = 2'b01;
  localparam logic [1:0]  ST_DROP  = 2'b10;
  localparam logic [1:0]  ST_TRUNC = 2'b11;
  localparam logic [13:0] MAX_L    = 14'(MAX_LEN);
  localparam logic [9:0]  DEPTH_W  = 10'(DEPTH);
  localparam logic [9:0]  ADMIT_W  = 10'(ADMIT_FREE);

  state_t      state;
  state_t      state_nx;
  logic [13:0] len;
  logic [13:0] len_nx;
  logic [1:0]  sts;
  logic [1:0]  sts_nx;
  logic        en_q;
  logic        en_nx;
  logic        wr_nx;
  logic [7:0]  wd_nx;
  logic        done_nx;
  logic [15:0] drop_q;
  logic [9:0]  free_slots;
  logic        admit;
  logic        cand_ok;
  logic [7:0]  cand;

  assign free_slots = DEPTH_W - {1'b0, fifo_usedw};
  assign admit      = en_q && (free_slots >= ADMIT_W);
  assign drop_cnt   = drop_q;

`ifdef GIGERX_RX_CRC_STRIP_EN
  // A byte only leaves the delay line once four newer bytes sit behind it.
  logic [3:0][7:0] dl;
  logic [2:0]      dl_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl     <= '0;
      dl_cnt <= '0;
    end else if (state == RECV && rx_dv) begin
      dl <= {dl[2:0], rxd};
      if (dl_cnt != 3'd4) dl_cnt <= dl_cnt + 3'd1;
    end else begin
      dl_cnt <= '0;
    end
  end

  assign cand_ok = (dl_cnt == 3'd4);
  assign cand    = dl[3];
`else
  assign cand_ok = 1'b1;
  assign cand    = rxd;
`endif

  always_comb begin
    state_nx = state;
    len_nx   = len;
    sts_nx   = sts;
    en_nx    = en_q;
    wr_nx    = 1'b0;
    wd_nx    = fifo_data;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        en_nx = cfg_en;
        if (rx_dv) begin
          if (rxd == 8'h55) begin
            state_nx = PREAMBLE;
          end else begin
            state_nx = DISCARD;
            sts_nx   = ST_DROP;
            len_nx   = '0;
          end
        end
      end
      PREAMBLE: begin
        if (!rx_dv) begin
          state_nx = IDLE;
        end else if (rxd == 8'hD5) begin
          len_nx = '0;
          if (admit) begin
            state_nx = RECV;
            sts_nx   = ST_GOOD;
          end else begin
            state_nx = DISCARD;
            sts_nx   = ST_DROP;
          end
        end else if (rxd != 8'h55) begin
          state_nx = DISCARD;
          sts_nx   = ST_DROP;
          len_nx   = '0;
        end
      end
      RECV: begin
        if (!rx_dv) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          if (rx_er && sts == ST_GOOD) sts_nx = ST_ERR;
          // Truncation is sticky: once set, nothing more is written.
          if (cand_ok && sts != ST_TRUNC) begin
            if (fifo_full || len == MAX_L) begin
              sts_nx = ST_TRUNC;
            end else begin
              wr_nx  = 1'b1;
              wd_nx  = cand;
              len_nx = len + 14'd1;
            end
          end
        end
      end
      DISCARD: begin
        if (!rx_dv) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len        <= '0;
      sts        <= '0;
      en_q       <= 1'b0;
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
      frm_done   <= 1'b0;
      frm_len    <= '0;
      frm_status <= '0;
      drop_q     <= '0;
    end else begin
      state      <= state_nx;
      len        <= len_nx;
      sts        <= sts_nx;
      en_q       <= en_nx;
      fifo_wrreq <= wr_nx;
      fifo_data  <= wd_nx;
      frm_done   <= done_nx;
      if (done_nx) begin
        frm_len    <= len;
        frm_status <= sts;
      end
      if (done_nx && sts == ST_DROP && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_gigerx_rx_wr_ctrl.sv
// Bench for gigerx_rx_wr_ctrl: frame-level model, per-cycle compare, pins.
// Honours GIGERX_RX_CRC_STRIP_EN for the expected write set.
module tb_gigerx_rx_wr_ctrl;

`ifdef GIGERX_RX_CRC_STRIP_EN
  localparam int D = 4;
`else
  localparam int D = 0;
`endif
  localparam int MAXL = 1522;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_en = 1'b1;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic [8:0]  fifo_usedw = 9'd0;
  logic        fifo_full = 1'b0;
  logic        fifo_wrreq;
  logic [7:0]  fifo_data;
  logic        frm_done;
  logic [13:0] frm_len;
  logic [1:0]  frm_status;
  logic [15:0] drop_cnt;
  logic        w16_wrreq;
  logic [7:0]  w16_data;
  logic        w16_done;
  logic [13:0] w16_len;
  logic [1:0]  w16_status;
  logic [15:0] w16_drop;

  always #5 clk = ~clk;

  gigerx_rx_wr_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en),
    .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .fifo_usedw(fifo_usedw), .fifo_full(fifo_full),
    .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .frm_done(frm_done), .frm_len(frm_len),
    .frm_status(frm_status), .drop_cnt(drop_cnt)
  );

  gigerx_rx_wr_ctrl #(.MAX_LEN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en),
    .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .fifo_usedw(fifo_usedw), .fifo_full(fifo_full),
    .fifo_wrreq(w16_wrreq), .fifo_data(w16_data),
    .frm_done(w16_done), .frm_len(w16_len),
    .frm_status(w16_status), .drop_cnt(w16_drop)
  );

  typedef struct {
    logic [13:0] len;
    logic [1:0]  st;
    int          wtot;
  } ev_t;

  logic [7:0]  exp_w[$];
  ev_t         exp_e[$];
  ev_t         ev;
  logic [13:0] m_len = '0;
  logic [1:0]  m_st = '0;
  logic [15:0] m_drop = '0;
  int          m_wtot = 0;
  int          wr_total = 0;
  int          n16 = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (w16_wrreq) n16++;
      if (fifo_wrreq) begin
        wr_total++;
        if (exp_w.size() == 0) chk("unexpected write", 1, 0);
        else chk("wr data", int'(fifo_data), int'(exp_w.pop_front()));
      end
      if (frm_done) begin
        if (exp_e.size() == 0) begin
          chk("unexpected done", 1, 0);
        end else begin
          ev = exp_e.pop_front();
          m_len = ev.len;
          m_st  = ev.st;
          if (ev.st == 2'b10 && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
          chk("writes before done", wr_total, ev.wtot);
        end
      end
      chk("frm_len", int'(frm_len), int'(m_len));
      chk("frm_status", int'(frm_status), int'(m_st));
      chk("drop_cnt", int'(drop_cnt), int'(m_drop));
    end
  end

  task automatic drv(input logic dv, input logic [7:0] d,
                     input logic er, input logic full);
    @(posedge clk);
    #1;
    rx_dv = dv;
    rxd = d;
    rx_er = er;
    fifo_full = full;
  endtask

  task automatic send_frame(input int n, input int usedw, input int full_at,
                            input int er_at, input logic en,
                            input logic [7:0] sfd, input int gap);
    logic [1:0] st;
    int wr;
    logic stp;
    cfg_en = en;
    fifo_usedw = 9'(usedw);
    if (!(sfd == 8'hD5 && en && (256 - usedw) >= 64)) begin
      exp_e.push_back('{14'd0, 2'b10, m_wtot});
    end else begin
      st = (er_at >= 0 && er_at < n) ? 2'b01 : 2'b00;
      wr = 0;
      stp = 1'b0;
      for (int i = 0; i < n - D; i++) begin
        if ((full_at >= 0 && i + D >= full_at) || wr == MAXL) begin
          stp = 1'b1;
          break;
        end
        exp_w.push_back(i[7:0]);
        wr++;
      end
      m_wtot += wr;
      if (stp) st = 2'b11;
      exp_e.push_back('{14'(wr), st, m_wtot});
    end
    for (int i = 0; i < 7; i++) drv(1'b1, 8'h55, 1'b0, 1'b0);
    drv(1'b1, sfd, 1'b0, 1'b0);
    for (int i = 0; i < n; i++)
      drv(1'b1, i[7:0], i == er_at, full_at >= 0 && i >= full_at);
    for (int i = 0; i < gap; i++) drv(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_junk();
    exp_e.push_back('{14'd0, 2'b10, m_wtot});
    drv(1'b1, 8'h00, 1'b0, 1'b0);
    drv(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_w.size() != 0 || exp_e.size() != 0) && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (exp_w.size() != 0 || exp_e.size() != 0) begin
      chk("drain timeout", exp_w.size() + exp_e.size(), 0);
      exp_w.delete();
      exp_e.delete();
      m_wtot = wr_total;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pin(input string nm, input int w0, input int ew,
                     input int el, input int es);
    chk({nm, " writes"}, wr_total - w0, ew);
    chk({nm, " len"}, int'(frm_len), el);
    chk({nm, " status"}, int'(frm_status), es);
  endtask

  int w0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst wrreq", int'(fifo_wrreq), 0);
    chk("rst data", int'(fifo_data), 0);
    chk("rst done", int'(frm_done), 0);
    chk("rst len", int'(frm_len), 0);
    chk("rst status", int'(frm_status), 0);
    chk("rst drop", int'(drop_cnt), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    w0 = wr_total;
    send_frame(64, 0, -1, -1, 1'b1, 8'hD5, 2);
    drain();
    pin("good", w0, 64 - D, 64 - D, 0);

    w0 = wr_total;
    send_frame(16, 200, -1, -1, 1'b1, 8'hD5, 2);
    drain();
    pin("usedw200", w0, 0, 0, 2);
    chk("usedw200 drop_cnt", int'(drop_cnt), 1);

    w0 = wr_total;
    send_frame(16, 192, -1, -1, 1'b1, 8'hD5, 2);
    drain();
    pin("usedw192", w0, 16 - D, 16 - D, 0);

    w0 = wr_total;
    send_frame(30, 0, 10 + D, -1, 1'b1, 8'hD5, 2);
    drain();
    pin("full", w0, 10, 10, 3);

    w0 = wr_total;
    send_frame(20, 0, -1, 5, 1'b1, 8'hD5, 2);
    drain();
    pin("rx_er", w0, 20 - D, 20 - D, 1);

    w0 = wr_total;
    send_frame(20, 0, 8 + D, 3, 1'b1, 8'hD5, 2);
    drain();
    pin("er+full", w0, 8, 8, 3);

    w0 = wr_total;
    send_frame(16, 0, -1, -1, 1'b0, 8'hD5, 2);
    drain();
    pin("disabled", w0, 0, 0, 2);
    chk("disabled drop_cnt", int'(drop_cnt), 2);

    w0 = wr_total;
    send_frame(8, 0, -1, -1, 1'b1, 8'h5D, 2);
    drain();
    pin("bad sfd", w0, 0, 0, 2);

    w0 = wr_total;
    for (int i = 0; i < 3; i++) drv(1'b1, 8'h55, 1'b0, 1'b0);
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    chk("pre abort writes", wr_total - w0, 0);

    w0 = wr_total;
    send_frame(3, 0, -1, -1, 1'b1, 8'hD5, 2);
    drain();
    pin("short", w0, (D == 0) ? 3 : 0, (D == 0) ? 3 : 0, 0);

    w0 = n16;
    send_frame(40, 0, -1, -1, 1'b1, 8'hD5, 2);
    drain();
    pin("max1522", wr_total - (40 - D), 40 - D, 40 - D, 0);
    chk("max16 writes", n16 - w0, 16);
    chk("max16 len", int'(w16_len), 16);
    chk("max16 status", int'(w16_status), 3);

    w0 = wr_total;
    send_frame(12, 0, -1, -1, 1'b1, 8'hD5, 1);
    send_frame(12, 0, -1, 2, 1'b1, 8'hD5, 1);
    drain();
    pin("back2back", w0, 2 * (12 - D), 12 - D, 1);

    @(posedge clk);
    #2;
    force dut.drop_q = 16'hFFFD;
    m_drop = 16'hFFFD;
    #1;
    release dut.drop_q;
    for (int i = 0; i < 3; i++) send_junk();
    drain();
    chk("drop sat", int'(drop_cnt), 16'hFFFF);

    w0 = wr_total;
    cfg_en = 1'b1;
    fifo_usedw = 9'd0;
    for (int i = 0; i <= 8 - D; i++) exp_w.push_back(i[7:0]);
    m_wtot += 9 - D;
    for (int i = 0; i < 7; i++) drv(1'b1, 8'h55, 1'b0, 1'b0);
    drv(1'b1, 8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drv(1'b1, i[7:0], 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    rx_dv = 1'b0;
    #1;
    chk("mid rst wrreq", int'(fifo_wrreq), 0);
    chk("mid rst data", int'(fifo_data), 0);
    chk("mid rst done", int'(frm_done), 0);
    chk("mid rst len", int'(frm_len), 0);
    chk("mid rst status", int'(frm_status), 0);
    chk("mid rst drop", int'(drop_cnt), 0);
    chk("pre-reset writes", wr_total - w0, 9 - D);
    exp_w.delete();
    exp_e.delete();
    m_len = '0;
    m_st = '0;
    m_drop = '0;
    m_wtot = wr_total;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;

    w0 = wr_total;
    send_frame(20, 0, -1, -1, 1'b1, 8'hD5, 2);
    drain();
    pin("after rst", w0, 20 - D, 20 - D, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
